// File: rtl/atm_balance_arbiter.sv
// rtl/atm_balance_arbiter.sv - round-robin arbiter serialising four requesters onto one shared balance
module atm_balance_arbiter #(
    parameter int BAL_W    = 8,
    parameter int AMT_W    = 6,
    parameter int INIT_BAL = 30,
    parameter int MAX_BAL  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             req_valid,
    input  logic [7:0]             req_op,
    input  logic [4*AMT_W-1:0]     req_amt,
    output logic [3:0]             req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [1:0]             rsp_status,
    output logic [BAL_W-1:0]       rsp_balance,
    output logic [BAL_W-1:0]       balance,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_INQ = 2'd0;
    localparam logic [1:0] OP_DEP = 2'd1;
    localparam logic [1:0] OP_WDR = 2'd2;

    localparam logic [1:0] STS_OK  = 2'd0;
    localparam logic [1:0] STS_NSF = 2'd1;
    localparam logic [1:0] STS_OVF = 2'd2;
    localparam logic [1:0] STS_BAD = 2'd3;

    // One extra bit of headroom so deposits are compared before any wrap.
    localparam logic [BAL_W:0]   MAX_EXT  = (BAL_W+1)'(MAX_BAL);
    localparam logic [BAL_W-1:0] INIT_VAL = BAL_W'(INIT_BAL);

    logic [1:0]       state;
    logic [1:0]       last_grant;
    logic [1:0]       grant_id;
    logic [1:0]       cand;
    logic             grant_hit;
    logic [1:0]       sel_op;
    logic [AMT_W-1:0] sel_amt;
    logic [1:0]       op_q;
    logic [1:0]       id_q;
    logic [AMT_W-1:0] amt_q;
    logic [BAL_W:0]   amt_ext;
    logic [BAL_W:0]   sum;
    logic [BAL_W-1:0] next_bal;
    logic [1:0]       next_status;

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        grant_id  = 2'd0;
        grant_hit = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!grant_hit && req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Pick the winner's op and amount out of the packed request buses.
    always_comb begin
        sel_op  = 2'd0;
        sel_amt = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_id == 2'(i)) begin
                sel_op  = req_op[2*i +: 2];
                sel_amt = req_amt[AMT_W*i +: AMT_W];
            end
        end
    end

    // Outcome of the latched transaction, evaluated at BAL_W+1 bits.
    always_comb begin
        amt_ext     = (BAL_W+1)'(amt_q);
        sum         = {1'b0, balance} + amt_ext;
        next_bal    = balance;
        next_status = STS_OK;
        case (op_q)
            OP_INQ: next_status = STS_OK;
            OP_DEP: begin
                if (sum > MAX_EXT) next_status = STS_OVF;
                else               next_bal    = sum[BAL_W-1:0];
            end
            OP_WDR: begin
                if (amt_ext > {1'b0, balance}) next_status = STS_NSF;
                else                           next_bal    = balance - BAL_W'(amt_q);
            end
            default: next_status = STS_BAD;
        endcase
    end

    // Grant strobe is only offered while idle; it doubles as the accept.
    always_comb begin
        req_ready = 4'd0;
        if (state == ST_IDLE && grant_hit) req_ready = 4'd1 << grant_id;
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // Three-state sequencer: accept, apply to balance, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            balance     <= INIT_VAL;
            last_grant  <= 2'd3;
            op_q        <= 2'd0;
            amt_q       <= '0;
            id_q        <= 2'd0;
            rsp_id      <= 2'd0;
            rsp_status  <= 2'd0;
            rsp_balance <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_hit) begin
                        op_q       <= sel_op;
                        amt_q      <= sel_amt;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    balance     <= next_bal;
                    rsp_id      <= id_q;
                    rsp_status  <= next_status;
                    rsp_balance <= next_bal;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// tb/tb_atm_balance_arbiter.sv - self-checking bench for atm_balance_arbiter
module tb_atm_balance_arbiter;

    localparam int BAL_W = 8;
    localparam int AMT_W = 6;

    logic                 clk;
    logic                 rst;
    logic [3:0]           req_valid;
    logic [7:0]           req_op;
    logic [4*AMT_W-1:0]   req_amt;
    logic [3:0]           req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [1:0]           rsp_status;
    logic [BAL_W-1:0]     rsp_balance;
    logic [BAL_W-1:0]     balance;
    logic                 busy;

    int checks;
    int errors;
    int m_bal;
    int m_last;

    atm_balance_arbiter #(
        .BAL_W(BAL_W), .AMT_W(AMT_W), .INIT_BAL(30), .MAX_BAL(255)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_amt(req_amt),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
        .balance(balance), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    // Reference outcome: status code and resulting balance.
    task automatic model(input int op, input int amt, output int st, output int nb);
        nb = m_bal;
        st = 0;
        if (op == 1) begin
            if (m_bal + amt > 255) st = 2;
            else nb = m_bal + amt;
        end else if (op == 2) begin
            if (amt > m_bal) st = 1;
            else nb = m_bal - amt;
        end else if (op == 3) begin
            st = 3;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'd0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_bal = 30;
        m_last = 3;
    endtask

    // Entered at posedge+1 with the DUT idle; leaves at posedge+1, idle again.
    task automatic run_req(input logic [3:0] v, input logic [7:0] ops,
                           input logic [4*AMT_W-1:0] amts, input int stall);
        int w, op_i, amt_i, st, nb;
        logic [1:0] op2;
        logic [AMT_W-1:0] a6;
        req_valid = v; req_op = ops; req_amt = amts; rsp_ready = (stall == 0);
        #1;
        w = rr_pick(v);
        chk("grant", 32'(req_ready), 32'(1 << w));
        op2 = ops[2*w +: 2];
        a6 = amts[AMT_W*w +: AMT_W];
        op_i = int'(op2);
        amt_i = int'(a6);
        model(op_i, amt_i, st, nb);
        m_last = w;
        @(posedge clk); #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("rsp_status", 32'(rsp_status), 32'(st));
        chk("rsp_balance", 32'(rsp_balance), 32'(nb));
        chk("balance", 32'(balance), 32'(nb));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_id", 32'(rsp_id), 32'(w));
            chk("stall_status", 32'(rsp_status), 32'(st));
            chk("stall_balance", 32'(rsp_balance), 32'(nb));
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_bal = nb;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_regrant", 32'(req_ready), 32'(1 << rr_pick(v)));
    endtask

    function automatic logic [4*AMT_W-1:0] amt_all(input int a);
        logic [4*AMT_W-1:0] r;
        for (int i = 0; i < 4; i++) r[AMT_W*i +: AMT_W] = AMT_W'(a);
        return r;
    endfunction

    initial begin
        logic [3:0] v;
        logic [7:0] ops;
        logic [4*AMT_W-1:0] amts;
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 4'd0; req_op = 8'd0; req_amt = '0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_bal = 30; m_last = 3;
        chk("rst_balance", 32'(balance), 32'd30);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_balance", 32'(rsp_balance), 32'd0);

        // Deposit 20 from requester 0 -> 50
        run_req(4'b0001, 8'h01, amt_all(20), 0);
        chk("dep20_balance", 32'(balance), 32'd50);

        // Insufficient funds, then exact withdraw to zero
        do_reset();
        run_req(4'b0001, 8'h02, amt_all(31), 0);
        chk("wdr31_balance", 32'(balance), 32'd30);
        run_req(4'b0001, 8'h02, amt_all(30), 0);
        chk("wdr30_balance", 32'(balance), 32'd0);

        // Climb to 250, zero amount, exact MAX, overflow, bad op
        run_req(4'b0001, 8'h01, amt_all(63), 0);
        run_req(4'b0001, 8'h01, amt_all(63), 0);
        run_req(4'b0001, 8'h01, amt_all(63), 0);
        run_req(4'b0001, 8'h01, amt_all(61), 0);
        chk("bal250", 32'(balance), 32'd250);
        run_req(4'b0001, 8'h01, amt_all(0), 0);
        run_req(4'b0001, 8'h01, amt_all(5), 0);
        chk("bal255", 32'(balance), 32'd255);
        run_req(4'b0001, 8'h01, amt_all(1), 0);
        chk("ovf_balance", 32'(balance), 32'd255);
        run_req(4'b0001, 8'h03, amt_all(7), 0);
        chk("badop_balance", 32'(balance), 32'd255);

        // Four inquiries held from reset: grants every third cycle 0,1,2,3,0
        do_reset();
        req_op = 8'h00; req_amt = '0; rsp_ready = 1'b1;
        rst = 1'b1; req_valid = 4'b1111;
        #1; rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            #1;
            chk("rr_order", 32'(req_ready), (c % 3 == 0) ? 32'(1 << ((c / 3) % 4)) : 32'd0);
            @(posedge clk); #1;
        end

        // Response back-pressure for 5 cycles with all requesters waiting
        do_reset();
        run_req(4'b1111, 8'h00, amt_all(0), 5);
        run_req(4'b1111, 8'b01_01_01_01, amt_all(9), 5);

        // Reset during EXEC of a deposit aborts it
        do_reset();
        req_valid = 4'b0100; req_op = 8'b00_01_00_00; req_amt = amt_all(10);
        #1;
        chk("abort_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        chk("abort_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_balance", 32'(balance), 32'd30);
        @(posedge clk); #1;
        chk("abort_hold_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0; m_bal = 30; m_last = 3;
        req_valid = 4'b1111; req_op = 8'h00;
        #1;
        chk("abort_next_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'd0;
        @(posedge clk); #1;
        do_reset();

        // Randomised transactions checked against the reference model
        for (int n = 0; n < 60; n++) begin
            v = 4'($urandom_range(1, 15));
            ops = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ops = 8'hFF;
            amts = (4*AMT_W)'($urandom);
            run_req(v, ops, amts, int'($urandom_range(0, 2)));
        end
        req_valid = 4'd0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
